// File: rtl/wallace_accumulator.sv
// wallace_accumulator
// Accumulate stage behind the 4x4 Wallace multiplier. It sums COUNT products
// into a saturating ACC_W-bit accumulator and holds the total on a
// valid/ready output until the consumer takes it.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_ACC  | taking products; acc_out shows the running sum
// ST_DONE | result complete; acc_out/overflow frozen until out_ready
//
// Legal parameter range: 1 <= COUNT <= 256, ACC_W >= 8.

module wallace_accumulator #(
  parameter int COUNT = 8,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       prod_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clear,
  output logic [ACC_W-1:0] acc_out,
  output logic             overflow,
  output logic             out_valid,
  input  logic             out_ready
);

  // One extra bit so cnt can hold COUNT-1 for every legal COUNT, including 1.
  localparam int CNT_W = $clog2(COUNT) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ovf;
  logic             ovf_nxt;
  logic             vld;
  logic             vld_nxt;
  logic             accept;
  logic [ACC_W:0]   sum;

  // Ready is withheld during reset, while a result is waiting and during clear,
  // so a clear always wins over a product offered in the same cycle.
  assign in_ready = rst_n & (state == ST_ACC) & ~clear;
  assign accept   = in_valid & in_ready;

  // The carry out of the top bit is the saturation indicator.
  assign sum = {1'b0, acc} + {{(ACC_W - 7){1'b0}}, prod_in};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_ACC;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath update selection.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf;
    vld_nxt   = vld;
    case (state)
      ST_ACC: begin
        if (clear) begin
          acc_nxt = '0;
          cnt_nxt = '0;
          ovf_nxt = 1'b0;
        end else if (accept) begin
          cnt_nxt = cnt + CNT_W'(1);
          // Once saturated, the result stays pinned at full scale.
          if (sum[ACC_W] || ovf) begin
            acc_nxt = '1;
            ovf_nxt = 1'b1;
          end else begin
            acc_nxt = sum[ACC_W-1:0];
          end
          if (cnt == LAST) begin
            state_nxt = ST_DONE;
            vld_nxt   = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_nxt = ST_ACC;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          ovf_nxt   = 1'b0;
          vld_nxt   = 1'b0;
        end
      end
      default: begin
        state_nxt = ST_ACC;
      end
    endcase
  end

  // Accumulator, count, sticky overflow and result-valid registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      vld <= 1'b0;
    end else begin
      acc <= acc_nxt;
      cnt <= cnt_nxt;
      ovf <= ovf_nxt;
      vld <= vld_nxt;
    end
  end

  assign acc_out   = acc;
  assign overflow  = ovf;
  assign out_valid = vld;

endmodule

// File: tb/tb_wallace_accumulator.sv
// Bench for wallace_accumulator: three instances (8x16-bit, 8x10-bit and
// 1x8-bit) share the same stimulus and are each compared every cycle against
// a sum-and-count reference model.

module tb_wallace_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  prod_in = '0;
  logic        in_valid = 1'b0;
  logic        clear = 1'b0;
  logic        out_ready = 1'b0;

  logic        ir_a, ovf_a, ov_a;
  logic [15:0] acc_a;
  logic        ir_b, ovf_b, ov_b;
  logic [9:0]  acc_b;
  logic        ir_c, ovf_c, ov_c;
  logic [7:0]  acc_c;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wallace_accumulator #(.COUNT(8), .ACC_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .prod_in(prod_in), .in_valid(in_valid),
    .in_ready(ir_a), .clear(clear), .acc_out(acc_a), .overflow(ovf_a),
    .out_valid(ov_a), .out_ready(out_ready));

  wallace_accumulator #(.COUNT(8), .ACC_W(10)) dut_b (
    .clk(clk), .rst_n(rst_n), .prod_in(prod_in), .in_valid(in_valid),
    .in_ready(ir_b), .clear(clear), .acc_out(acc_b), .overflow(ovf_b),
    .out_valid(ov_b), .out_ready(out_ready));

  wallace_accumulator #(.COUNT(1), .ACC_W(8)) dut_c (
    .clk(clk), .rst_n(rst_n), .prod_in(prod_in), .in_valid(in_valid),
    .in_ready(ir_c), .clear(clear), .acc_out(acc_c), .overflow(ovf_c),
    .out_valid(ov_c), .out_ready(out_ready));

  // Reference model: plain integer sum, accepted-product count, done flag.
  int m_count[3] = '{8, 8, 1};
  int m_max[3]   = '{65535, 1023, 255};
  int m_sum[3]   = '{0, 0, 0};
  int m_n[3]     = '{0, 0, 0};
  bit m_ovf[3]   = '{0, 0, 0};
  bit m_done[3]  = '{0, 0, 0};

  function automatic int dut_ready(int k);
    case (k)
      0: return int'(ir_a);
      1: return int'(ir_b);
      default: return int'(ir_c);
    endcase
  endfunction

  function automatic int dut_acc(int k);
    case (k)
      0: return int'(acc_a);
      1: return int'(acc_b);
      default: return int'(acc_c);
    endcase
  endfunction

  function automatic int dut_ovf(int k);
    case (k)
      0: return int'(ovf_a);
      1: return int'(ovf_b);
      default: return int'(ovf_c);
    endcase
  endfunction

  function automatic int dut_valid(int k);
    case (k)
      0: return int'(ov_a);
      1: return int'(ov_b);
      default: return int'(ov_c);
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, wanted %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input int p, input bit v, input bit c, input bit o);
    rst_n     = r;
    prod_in   = 8'(p);
    in_valid  = v;
    clear     = c;
    out_ready = o;
  endtask

  // One clock: check in_ready, advance the model at the edge, check outputs.
  // Called just after a falling edge with inputs already driven.
  task automatic cycle();
    bit rdy[3];
    #1;
    for (int k = 0; k < 3; k++) begin
      rdy[k] = rst_n && !m_done[k] && !clear;
      check($sformatf("in_ready[%0d]", k), dut_ready(k), int'(rdy[k]));
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        m_sum[k] = 0; m_n[k] = 0; m_ovf[k] = 0; m_done[k] = 0;
      end else if (m_done[k]) begin
        if (out_ready) begin
          m_sum[k] = 0; m_n[k] = 0; m_ovf[k] = 0; m_done[k] = 0;
        end
      end else if (clear) begin
        m_sum[k] = 0; m_n[k] = 0; m_ovf[k] = 0;
      end else if (in_valid && rdy[k]) begin
        m_n[k]++;
        if (m_ovf[k] || (m_sum[k] + int'(prod_in) > m_max[k])) begin
          m_sum[k] = m_max[k];
          m_ovf[k] = 1;
        end else begin
          m_sum[k] = m_sum[k] + int'(prod_in);
        end
        if (m_n[k] == m_count[k]) m_done[k] = 1;
      end
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("acc_out[%0d]", k), dut_acc(k), m_sum[k]);
      check($sformatf("overflow[%0d]", k), dut_ovf(k), int'(m_ovf[k]));
      check($sformatf("out_valid[%0d]", k), dut_valid(k), int'(m_done[k]));
    end
    @(negedge clk);
  endtask

  typedef struct {
    bit r; int p; bit v; bit c; bit o;
    bit exp_ready; int exp_acc_a; bit exp_valid_a; int exp_acc_b; bit exp_ovf_b;
  } vec_t;

  vec_t tbl[24];

  initial begin
    int idx, accepts, results, cyc;
    bit v, o;

    // Directed vectors for the 8x16 instance (acc/valid) and the 10-bit one
    // (saturation after the 5th product of 225).
    tbl[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 1; i <= 8; i++)
      tbl[i] = '{1, 225, 1, 0, 1, 1, 225 * i, (i == 8),
                 (i <= 4) ? 225 * i : 1023, (i > 4)};
    tbl[9]  = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    tbl[10] = '{1, 10, 1, 0, 1, 1, 10, 0, 10, 0};
    tbl[11] = '{1, 20, 1, 0, 1, 1, 30, 0, 30, 0};
    tbl[12] = '{1, 30, 1, 0, 1, 1, 60, 0, 60, 0};
    tbl[13] = '{1, 40, 1, 1, 1, 0, 0, 0, 0, 0};
    for (int j = 1; j <= 8; j++)
      tbl[13 + j] = '{1, 1, 1, 0, 1, 1, j, (j == 8), j, 0};
    tbl[22] = '{1, 5, 1, 0, 0, 0, 8, 1, 8, 0};
    tbl[23] = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 0};

    repeat (2) @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].r, tbl[i].p, tbl[i].v, tbl[i].c, tbl[i].o);
      #1;
      check($sformatf("vec%0d in_ready", i), int'(ir_a), int'(tbl[i].exp_ready));
      cycle();
      check($sformatf("vec%0d acc_a", i), int'(acc_a), tbl[i].exp_acc_a);
      check($sformatf("vec%0d valid_a", i), int'(ov_a), int'(tbl[i].exp_valid_a));
      check($sformatf("vec%0d ovf_a", i), int'(ovf_a), 0);
      check($sformatf("vec%0d acc_b", i), int'(acc_b), tbl[i].exp_acc_b);
      check($sformatf("vec%0d ovf_b", i), int'(ovf_b), int'(tbl[i].exp_ovf_b));
    end

    // Backpressure: 8 x 15 = 120 held for 5 stalled cycles.
    for (int i = 0; i < 8; i++) begin
      drive(1, 15, 1, 0, 0);
      cycle();
    end
    check("bp result", int'(acc_a), 120);
    for (int i = 0; i < 5; i++) begin
      drive(1, 99, (i % 2) == 0, 0, 0);
      #1;
      check("bp in_ready", int'(ir_a), 0);
      cycle();
      check("bp acc held", int'(acc_a), 120);
      check("bp valid held", int'(ov_a), 1);
    end
    drive(1, 0, 0, 0, 1);
    cycle();
    check("bp after handshake", int'(acc_a), 0);

    // Reset while holding a result of 500.
    for (int i = 0; i < 8; i++) begin
      drive(1, (i == 7) ? 52 : 64, 1, 0, 0);
      cycle();
    end
    check("rst held 500", int'(acc_a), 500);
    check("rst held valid", int'(ov_a), 1);
    drive(0, 7, 1, 0, 0);
    cycle();
    check("rst valid", int'(ov_a), 0);
    check("rst acc", int'(acc_a), 0);
    check("rst ovf", int'(ovf_a), 0);
    check("rst in_ready low", int'(ir_a), 0);
    drive(1, 0, 0, 0, 0);
    #1;
    check("rst release in_ready", int'(ir_a), 1);
    cycle();

    // End-to-end: products k*k for k=0..7 (sum 140) with random gaps/stalls.
    idx = 0; accepts = 0; results = 0; cyc = 0;
    while (results < 4 && cyc < 3000) begin
      v = ($urandom_range(0, 3) != 0);
      o = ($urandom_range(0, 2) != 0);
      drive(1, idx * idx, v, 0, o);
      #1;
      if (ov_a && o) begin
        check("e2e result", int'(acc_a), 140);
        check("e2e accepts per result", accepts, 8);
        accepts = 0;
        results++;
      end
      if (ir_a && v) begin
        accepts++;
        idx = (idx + 1) % 8;
      end
      cycle();
      cyc++;
    end
    check("e2e results within budget", results, 4);

    // Free-running random traffic against the model, including clears and resets.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 49) != 0, $urandom_range(0, 225),
            $urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0,
            $urandom_range(0, 2) != 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
